jk_reg_bank: RTL
================

// Module: jk_reg_bank
// PURPOSE
//   WIDTH-bit register bank built from JK flip-flop cells. Generalises the single JK flop.
//   Modes: per-bit JK update, synchronous toggle-chain counter, parallel load, hold.
//   Used as a configurable state/counter register in small control datapaths.
//   Single clock domain; all outputs are registered or direct inversions of registers.
// PARAMETERS
//   WIDTH      8   bank width in bits (>=2)
//   RESET_VAL  0   value loaded into q on reset (WIDTH bits)
// PORTS
//   clk       in   1      rising-edge clock
//   reset     in   1      synchronous reset, active-high
//   en        in   1      update enable; 0 = hold all state
//   mode      in   2      00 JK, 01 COUNT, 10 LOAD, 11 HOLD
//   j         in   WIDTH  per-bit J inputs (mode JK)
//   k         in   WIDTH  per-bit K inputs (mode JK)
//   load_val  in   WIDTH  parallel load data (mode LOAD)
//   dir       in   1      count direction, 0 up / 1 down (only with JK_UPDOWN_EN)
//   q         out  WIDTH  register state
//   qbar      out  WIDTH  ~q, always
//   wrap      out  1      registered, 1 for the cycle after a counter wrap edge
// BEHAVIOUR
//   - One clock domain. Reset is synchronous and active-high.
//   - Priority at each rising clk edge: reset > en==0 > mode.
//   - Reset: q<=RESET_VAL, wrap<=0. qbar follows as ~RESET_VAL. Reset overrides any mode.
//   - Reset mid-count or mid-load discards that operation. No other state survives reset.
//   - en==0: q holds and wrap<=0, regardless of mode.
//   - JK (00), per bit i, per standard JK truth table:
//       jk=00 hold, 01 clear, 10 set, 11 toggle.
//       Equivalent: q_next = (j & ~q) | (~k & q). Bits are independent.
//   - COUNT (01): synchronous counter realised as a JK toggle chain.
//       Bit 0 always toggles.
//       Bit i toggles iff all bits [i-1:0] == 1 (up).
//       Wraps all-ones -> 0 modulo 2^WIDTH.
//   - LOAD (10): q<=load_val.
//   - HOLD (11): q unchanged.
//   - wrap<=1 on the same edge that q wraps in COUNT mode; otherwise wrap<=0.
//       Never set in JK, LOAD, HOLD or when en==0, even if q passes through a boundary value.
//   - Latency: one cycle from inputs to q for all modes. No combinational path from inputs to q, qbar or wrap.
//   - No X propagation: all WIDTH bits are defined after the first reset edge.
// CONFIGURATION
//   JK_UPDOWN_EN defined:
//     - dir port exists.
//     - dir==1 in COUNT: bit 0 toggles; bit i toggles iff bits [i-1:0] == 0.
//     - Down count wraps 0 -> all-ones, and wrap pulses on that edge.
//     - dir is ignored outside COUNT.
//   JK_UPDOWN_EN undefined:
//     - dir port absent; COUNT is up-only.
//     - Behaviour is otherwise identical.
// TESTING (WIDTH=8, RESET_VAL=0)
//   1. reset=1 for 2 edges, en=1, mode=COUNT -> q=0x00, qbar=0xFF, wrap=0.
//   2. Load q=0x0F, then JK with j=0xA5, k=0x3C, en=1 -> q=0xA3, qbar=0x5C next edge.
//   3. LOAD 0xFE, then COUNT 2 edges -> q=0xFF (wrap=0), then q=0x00 (wrap=1); one more edge -> 0x01, wrap=0.
//   4. q=0x10, mode=COUNT, en=0 for 3 edges -> q stays 0x10, wrap=0.
//      Then en=1 -> q=0x11.
//   5. COUNT from 0x07, reset=1 with mode=LOAD, load_val=0xAA -> q=0x00, wrap=0.
//      Reset wins over LOAD.
//   6. JK_UPDOWN_EN: LOAD 0x01, COUNT with dir=1 for 2 edges -> 0x00 (wrap=0), then 0xFF (wrap=1).

Source files
------------

// File: rtl/jk_reg_bank.sv
// jk_reg_bank: bank of JK flip-flop cells with per-bit JK update, toggle-chain count, parallel load and hold.
// Define JK_UPDOWN_EN to add the dir port, which selects down counting in COUNT mode.
module jk_reg_bank #(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] load_val,
`ifdef JK_UPDOWN_EN
    input  logic             dir,
`endif
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             wrap
);
    logic             down;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] jj;
    logic [WIDTH-1:0] kk;
    logic             cnt_wrap;
`ifdef JK_UPDOWN_EN
    assign down = dir;
`else
    assign down = 1'b0;
`endif
    // toggle chain: bit i flips once all lower bits sit at the carry (up) or borrow (down) value
    for (genvar i = 0; i < WIDTH; i++) begin : g_t
        if (i == 0) begin : g_lsb
            assign t[i] = 1'b1;
        end else begin : g_hi
            assign t[i] = down ? ~|q[i-1:0] : &q[i-1:0];
        end
    end
    assign cnt_wrap = t[WIDTH-1] & (q[WIDTH-1] ^ down);
    // every mode is expressed as J/K drive into the same cells
    always_comb begin
        jj = mode == 2'b00 ? j : mode == 2'b01 ? t : mode == 2'b10 ? load_val : '0;
        kk = mode == 2'b00 ? k : mode == 2'b01 ? t : mode == 2'b10 ? ~load_val : '0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            q    <= RESET_VAL;
            wrap <= 1'b0;
        end else if (!en) begin
            wrap <= 1'b0;
        end else begin
            q    <= (jj & ~q) | (~kk & q);
            wrap <= mode == 2'b01 && cnt_wrap;
        end
    end
    assign qbar = ~q;
endmodule
